mux_2to1: RTL and testbench
===========================

MUX_2TO1 -- requirements
Module: mux_2to1

Interface
REQ-001 Parameter WIDTH, default 1: data width of a, b, out, out_q.
REQ-002 Parameter CNT_W, default 16: width of the select-toggle counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port a, input, WIDTH: data input selected when sel=0.
REQ-006 Port b, input, WIDTH: data input selected when sel=1.
REQ-007 Port sel, input, 1: select line.
REQ-008 Port out, output, WIDTH: combinational mux result.
REQ-009 Port out_q, output, WIDTH: registered copy of out.
REQ-010 Port sel_q, output, 1: registered copy of sel.
REQ-011 Port sel_toggles, output, CNT_W: saturating count of sel changes since reset.

Function
REQ-012 out SHALL equal a when sel=0 and b when sel=1, with zero-cycle latency.
- Purely combinational.
- Independent of clk and rst_n.
- Valid within one simulation delta of any input change.
REQ-013 out SHALL be driven even while rst_n=0 and when clk never toggles.
REQ-014 When sel is X or Z in simulation, out SHALL be X on every bit where a and b differ, and SHALL equal a on bits where a equals b.
REQ-015 On each rising clk edge with rst_n=1, out_q SHALL load the current value of out, giving 1-cycle latency.
REQ-016 On each rising clk edge with rst_n=1, sel_q SHALL load sel.
REQ-017 sel_toggles SHALL increment by 1 on a rising clk edge when sel differs from sel_q.
REQ-018 sel_toggles SHALL hold at all-ones once reached, with no wrap-around.
REQ-019 When sel changes and returns to its previous value between two clk edges, the change SHALL NOT be counted (edge-sampled only).
REQ-020 The first edge after reset SHALL compare sel against sel_q=0, so sel=1 at that edge counts as one toggle.
REQ-021 a and b SHALL be treated as unsigned bit vectors, with no arithmetic performed on them.

Reset
REQ-022 When rst_n=0, out_q, sel_q and sel_toggles SHALL clear to 0 immediately, without waiting for clk.
REQ-023 When rst_n is asserted mid-operation, any pending counter increment SHALL be discarded.
REQ-024 Registered state SHALL resume updating on the first rising clk edge after rst_n deasserts.
REQ-025 Reset SHALL have no effect on the combinational out.

Structure
REQ-026 Shared package mux_2to1_pkg SHALL hold:
- default WIDTH and CNT_W constants;
- a typedef for the data word;
- a typedef for the counter.
REQ-027 The saturating counter SHALL be a sub-module named sat_counter, with ports clk, rst_n, inc and count.
REQ-028 All other logic SHALL be inline in mux_2to1.

Verification
REQ-029 Bench SHALL apply sel=0, a=1, b=0 -> out=1 after 1 time unit, no clock required.
REQ-030 Bench SHALL apply sel=1, a=1, b=0 -> out=0; then sel=0, a=0, b=1 -> out=0; then sel=1, a=0, b=1 -> out=1.
REQ-031 Bench SHALL set WIDTH=8, a=8'hA5, b=8'h3C and clock it:
- sel=0 -> out=8'hA5;
- one edge later out_q=8'hA5;
- sel=1 -> out=8'h3C, and out_q=8'h3C after the next edge.
REQ-032 Bench SHALL toggle sel on every edge for 5 edges after reset -> sel_toggles=5; with CNT_W=3 and 10 toggles -> sel_toggles=7 (saturated).
REQ-033 Bench SHALL assert rst_n=0 between clk edges with out_q=8'h3C and sel_toggles=4 -> out_q=0, sel_q=0 and sel_toggles=0 immediately, while out still equals the selected input.
REQ-034 Bench SHALL drive sel=X with a=8'hF0, b=8'hFF -> out upper nibble 4'hF and lower nibble X.

Source files
------------

// File: rtl/mux_2to1_pkg.sv
// Shared definitions for the mux_2to1 slice.
//   DEFAULT_WIDTH : default data width of a/b/out/out_q
//   DEFAULT_CNT_W : default width of the select-toggle counter
//   data_t        : data word at the default width
//   cnt_t         : toggle counter at the default width
package mux_2to1_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

    typedef logic [DEFAULT_WIDTH-1:0] data_t;
    typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   : clock, counts on rising edge
//   rst_n : asynchronous active-low clear
//   inc   : increment request, sampled on the rising edge
//   count : current count; sticks at all-ones instead of wrapping
module sat_counter
    import mux_2to1_pkg::*;
#(
    parameter int W = DEFAULT_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mux_2to1.sv
// 2:1 multiplexer with registered copies of its result and select, plus a
// saturating count of select changes seen on clock edges.
// Ports:
//   clk         : clock
//   rst_n       : asynchronous active-low reset (registered outputs only)
//   a, b        : data inputs (sel=0 picks a, sel=1 picks b)
//   sel         : select line
//   out         : combinational mux result, unaffected by clk and reset
//   out_q       : out registered on each rising edge
//   sel_q       : sel registered on each rising edge
//   sel_toggles : number of edges at which sel differed from sel_q
module mux_2to1
    import mux_2to1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] sel_toggles
);

    // The conditional operator merges a and b bitwise when sel is X/Z:
    // matching bits pass through, differing bits become X.
    assign out = sel ? b : a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            sel_q <= 1'b0;
        end else begin
            out_q <= out;
            sel_q <= sel;
        end
    end

    // Only the value present at the edge is compared, so a glitch that
    // returns to the old value between edges is never counted. sel_q
    // resets to 0, so sel=1 on the first edge counts as a toggle.
    logic toggle_inc;
    assign toggle_inc = (sel != sel_q);

    sat_counter #(
        .W(CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (toggle_inc),
        .count (sel_toggles)
    );

endmodule

// File: tb/tb_mux_2to1.sv
module tb_mux_2to1;

    logic clk = 1'b0;
    logic rst_n;

    // 1-bit instance for the basic truth-table vectors
    logic        a1, b1, sel1;
    logic        out1, out1_q, sel1_q;
    logic [15:0] tog1;

    // 8-bit instances sharing stimulus: 16-bit and 3-bit toggle counters
    logic [7:0]  a, b;
    logic        sel;
    logic [7:0]  out8, out8_q, out3, out3_q;
    logic        sel8_q, sel3_q;
    logic [15:0] tog8;
    logic [2:0]  tog3;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    mux_2to1 dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1),
        .out(out1), .out_q(out1_q), .sel_q(sel1_q), .sel_toggles(tog1)
    );

    mux_2to1 #(.WIDTH(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel),
        .out(out8), .out_q(out8_q), .sel_q(sel8_q), .sel_toggles(tog8)
    );

    mux_2to1 #(.WIDTH(8), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel),
        .out(out3), .out_q(out3_q), .sel_q(sel3_q), .sel_toggles(tog3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("[TB] ok %s = %h at %0t", name, act, $time);
        end
    endtask

    // Expected mux result: a for 0, b for 1, and for an unknown select
    // each bit is known only where a and b agree.
    function automatic logic [7:0] exp_out(input logic [7:0] ea, input logic [7:0] eb,
                                           input logic es);
        logic [7:0] r;
        if (es === 1'b0) return ea;
        if (es === 1'b1) return eb;
        for (int i = 0; i < 8; i++) r[i] = (ea[i] === eb[i]) ? ea[i] : 1'bx;
        return r;
    endfunction

    // Reference model: last sampled values and plain integer toggle counts.
    logic [7:0] m_out_q;
    logic       m_sel_q;
    int         m_cnt16;
    int         m_cnt3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out_q = 8'h00;
            m_sel_q = 1'b0;
            m_cnt16 = 0;
            m_cnt3  = 0;
        end else begin
            if (sel !== m_sel_q) begin
                if (m_cnt16 < 65535) m_cnt16 = m_cnt16 + 1;
                if (m_cnt3 < 7)      m_cnt3  = m_cnt3 + 1;
            end
            m_sel_q = sel;
            m_out_q = exp_out(a, b, sel);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_out8",   {24'h0, out8},   {24'h0, exp_out(a, b, sel)});
            chk("cyc_out3",   {24'h0, out3},   {24'h0, exp_out(a, b, sel)});
            chk("cyc_out8_q", {24'h0, out8_q}, {24'h0, m_out_q});
            chk("cyc_sel8_q", {31'h0, sel8_q}, {31'h0, m_sel_q});
            chk("cyc_tog8",   {16'h0, tog8},   32'(m_cnt16));
            chk("cyc_tog3",   {29'h0, tog3},   32'(m_cnt3));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0;
        a = 8'h00; b = 8'h00; sel = 1'b0;

        // Basic combinational vectors on the 1-bit instance, held in reset
        #1;
        sel1 = 1'b0; a1 = 1'b1; b1 = 1'b0; #1; chk("w1_s0_a1b0", {31'h0, out1}, 32'd1);
        sel1 = 1'b1; a1 = 1'b1; b1 = 1'b0; #1; chk("w1_s1_a1b0", {31'h0, out1}, 32'd0);
        sel1 = 1'b0; a1 = 1'b0; b1 = 1'b1; #1; chk("w1_s0_a0b1", {31'h0, out1}, 32'd0);
        sel1 = 1'b1; a1 = 1'b0; b1 = 1'b1; #1; chk("w1_s1_a0b1", {31'h0, out1}, 32'd1);

        // Reset state
        chk("rst_out_q", {24'h0, out8_q}, 32'h0);
        chk("rst_sel_q", {31'h0, sel8_q}, 32'h0);
        chk("rst_tog8",  {16'h0, tog8},   32'h0);
        chk("rst_tog3",  {29'h0, tog3},   32'h0);

        // 8-bit data path with 1-cycle registered copy
        @(negedge clk);
        a = 8'hA5; b = 8'h3C; sel = 1'b0;
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1; chk("w8_out_a", {24'h0, out8}, 32'hA5);
        step(); chk("w8_outq_a", {24'h0, out8_q}, 32'hA5);
        sel = 1'b1;
        #1; chk("w8_out_b", {24'h0, out8}, 32'h3C);
        step();
        chk("w8_outq_b", {24'h0, out8_q}, 32'h3C);
        chk("w8_selq",   {31'h0, sel8_q}, 32'h1);
        chk("w8_tog1",   {16'h0, tog8},   32'd1);

        // Fresh reset, then toggle sel on each of 10 edges
        rst_n = 1'b0; sel = 1'b0;
        #1; rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sel = ~sel;
            step();
        end
        chk("tog8_5", {16'h0, tog8}, 32'd5);
        chk("tog3_5", {29'h0, tog3}, 32'd5);
        for (int i = 0; i < 5; i++) begin
            sel = ~sel;
            step();
        end
        chk("tog8_10",    {16'h0, tog8}, 32'd10);
        chk("tog3_sat7",  {29'h0, tog3}, 32'd7);

        // Pending increment discarded by reset
        sel = 1'b1;
        #1; rst_n = 1'b0;
        #1; sel = 1'b0; rst_n = 1'b1;
        step();
        chk("pend_drop", {16'h0, tog8}, 32'd0);

        // Build out_q=3C, toggles=4, including a between-edge glitch
        sel = 1'b1; step();
        sel = 1'b1; #1; sel = 1'b0; #1; sel = 1'b1; #1; sel = 1'b0; step();
        sel = 1'b1; step();
        sel = 1'b0; a = 8'h3C; step();
        chk("pre_rst_outq", {24'h0, out8_q}, 32'h3C);
        chk("pre_rst_tog",  {16'h0, tog8},   32'd4);

        // Asynchronous reset between edges
        #1; rst_n = 1'b0;
        #1;
        chk("arst_outq", {24'h0, out8_q}, 32'h0);
        chk("arst_selq", {31'h0, sel8_q}, 32'h0);
        chk("arst_tog",  {16'h0, tog8},   32'h0);
        chk("arst_out",  {24'h0, out8},   32'h3C);

        // Unknown select while held in reset
        a = 8'hF0; b = 8'hFF; sel = 1'bx;
        #1;
        chk("x_hi", {28'h0, out8[7:4]}, 32'hF);
        chk("x_lo", {28'h0, out8[3:0]}, {28'h0, 4'bxxxx});
        step(); step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
